// File: rtl/clock_enable_controller_if.sv
// Control/status bundle for clock_enable_controller: mode, rate and step inputs,
// enable pulse and state outputs.
interface clock_enable_controller_if;
  logic [1:0] i_mode;
  logic [4:0] i_div_sel;
  logic       i_step_btn;
  logic       i_halt_req;
  logic       o_clk_en;
  logic [1:0] o_state;
  logic       o_halted;

  modport master (
    output i_mode, i_div_sel, i_step_btn, i_halt_req,
    input  o_clk_en, o_state, o_halted
  );

  modport slave (
    input  i_mode, i_div_sel, i_step_btn, i_halt_req,
    output o_clk_en, o_state, o_halted
  );
endinterface

// File: rtl/clock_enable_controller.sv
// Single-clock execution-rate controller: emits a one-cycle CLK_EN pulse for
// halt / free-run at 2^DIV_SEL / debounced single-step operation.
module clock_enable_controller #(
  parameter int CNT_WIDTH       = 24,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int DB_WIDTH        = 17
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  clock_enable_controller_if.slave   bus
);
  typedef enum logic [1:0] {
    S_HALT      = 2'b00,
    S_RUN       = 2'b01,
    S_STEP_WAIT = 2'b10,
    S_STEP_FIRE = 2'b11
  } state_t;

  localparam logic [4:0]           DIV_MAX = 5'(CNT_WIDTH - 1);
  localparam logic [DB_WIDTH-1:0]  DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_WIDTH-1:0]  DB_ONE  = DB_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                r_state;
  logic                  r_clk_en;
  logic                  r_halted;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [1:0]            r_sync;
  logic                  r_db_level;
  logic                  r_db_prev;
  logic [DB_WIDTH-1:0]   r_db_cnt;

  logic [4:0]            w_div_eff;
  logic [CNT_WIDTH-1:0]  w_term;
  logic                  w_step_req;

  assign w_div_eff  = (bus.i_div_sel > DIV_MAX) ? DIV_MAX : bus.i_div_sel;
  assign w_term     = (CNT_ONE << w_div_eff) - CNT_ONE;
  assign w_step_req = r_db_level & ~r_db_prev;

  // r_sync[0] may go metastable; only r_sync[1] feeds the debouncer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync     <= 2'b00;
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_sync    <= {r_sync[0], bus.i_step_btn};
      r_db_prev <= r_db_level;
      if (r_sync[1] == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_level <= r_sync[1];
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_HALT;
      r_clk_en <= 1'b0;
      r_halted <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_clk_en <= 1'b0;
      if (bus.i_halt_req)
        r_halted <= 1'b1;
      else if (r_state == S_HALT && bus.i_mode == 2'b00)
        r_halted <= 1'b0;

      case (r_state)
        S_HALT: begin
          if (bus.i_mode == 2'b01 && !r_halted) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end else if (bus.i_mode == 2'b10) begin
            r_state <= S_STEP_WAIT;
          end
        end
        S_RUN: begin
          // >= so a lowered DIV_SEL fires immediately instead of wrapping.
          if (bus.i_mode != 2'b01 || bus.i_halt_req) begin
            r_cnt   <= '0;
            r_state <= (bus.i_mode == 2'b10) ? S_STEP_WAIT : S_HALT;
          end else if (r_cnt >= w_term) begin
            r_clk_en <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_STEP_WAIT: begin
          if (w_step_req) begin
            r_clk_en <= 1'b1;
            r_state  <= S_STEP_FIRE;
          end else if (bus.i_mode == 2'b01 && !r_halted) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end else if (bus.i_mode == 2'b00 || bus.i_mode == 2'b11) begin
            r_state <= S_HALT;
          end
        end
        default: r_state <= S_STEP_WAIT;
      endcase
    end
  end

  assign bus.o_clk_en = r_clk_en;
  assign bus.o_state  = r_state;
  assign bus.o_halted = r_halted;
endmodule

// File: doc/clock_enable_controller.md
Name: clock_enable_controller

Overview:
Synchronous execution-rate controller for the processor core. It replaces ripple-divided clocks with a single-clock, one-cycle CLK_EN pulse, and the core advances only on cycles where CLK_EN is high. It supports halt, free-run at a programmable power-of-two rate, and debounced single-step from a push button, and it honours a halt request from the core.

Parameters:
CNT_WIDTH, 24, width of rate counter; max period 2^(CNT_WIDTH-1) cycles
DEBOUNCE_CYCLES, 100000, consecutive stable cycles needed to accept a STEP_BTN level (10 ms at 10 MHz)
DB_WIDTH, 17, width of debounce counter; must satisfy 2^DB_WIDTH > DEBOUNCE_CYCLES

Ports:
CLK  in  1  system clock, 10 MHz board clock
RST  in  1  asynchronous, active-high reset
MODE  in  2  00 halt, 01 run, 10 single-step, 11 reserved (treated as halt)
DIV_SEL  in  5  run period = 2^DIV_SEL cycles; values >= CNT_WIDTH clamp to CNT_WIDTH-1
STEP_BTN  in  1  raw asynchronous push button, active high
HALT_REQ  in  1  halt request from core (HLT executed), sampled every cycle
CLK_EN  out  1  registered one-cycle execution enable
STATE  out  2  00 HALT, 01 RUN, 10 STEP_WAIT, 11 STEP_FIRE
HALTED  out  1  sticky halt flag set by HALT_REQ

Behaviour:
- Reset (async, immediate, mid-operation included): CLK_EN=0, STATE=HALT, HALTED=0, rate counter=0, synchronizer flops=0, debounced level=0, debounce counter=0.
- STEP_BTN path: 2-flop synchronizer, then debouncer. The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free cycle clears the counter.
- step_req: one-cycle internal pulse on a 0->1 transition of the debounced level. A 1->0 transition generates nothing.
- Terminal count: term = 2^min(DIV_SEL, CNT_WIDTH-1) - 1.
- HALT state: CLK_EN=0.
  - MODE=01 and HALTED=0: go to RUN, counter=0.
  - MODE=10: go to STEP_WAIT.
  - MODE=00: clears HALTED.
- RUN state, per cycle:
  - If MODE!=01 or HALT_REQ=1: CLK_EN_next=0 and counter=0. Next state is STEP_WAIT if MODE=10, else HALT.
  - HALT_REQ=1 sets HALTED.
  - Otherwise, if counter>=term: CLK_EN_next=1 and counter=0.
  - Otherwise: CLK_EN_next=0 and counter+1.
  - The >= compare means that lowering DIV_SEL mid-run yields a pulse on the next cycle, then the new period.
- RUN timing: first CLK_EN high cycle is 2^DIV_SEL cycles after the first RUN cycle. It then repeats every 2^DIV_SEL cycles. DIV_SEL=0 gives CLK_EN continuously high.
- Simultaneous events in RUN: a CLK_EN already registered high in the cycle HALT_REQ or a mode change arrives is delivered. No further pulse is issued after that.
- STEP_WAIT state:
  - step_req: CLK_EN_next=1, go to STEP_FIRE.
  - Else MODE=01 with HALTED=0: go to RUN, counter=0.
  - Else MODE=00 or 11: go to HALT.
  - Step takes priority over a mode change in the same cycle.
  - HALTED does not block stepping. HALT_REQ sets HALTED but stays in STEP_WAIT.
- STEP_FIRE state: CLK_EN high for exactly this one cycle. Unconditionally return to STEP_WAIT, and let the next cycle re-evaluate MODE. A step_req arriving in STEP_FIRE is discarded.
- step_req in HALT or RUN: discarded, never queued.
- HALTED: set by HALT_REQ in any state. Cleared only while in HALT with MODE=00. While set, RUN cannot be entered.
- CLK_EN is a flop output with no combinational path from inputs. At most one CLK_EN cycle is produced per step_req.

Test Plan:
- Reset/idle: RST pulse mid-RUN at DIV_SEL=0 -> CLK_EN drops to 0 within the same cycle. STATE=00, HALTED=0, and both stay so with MODE=00 for 20 cycles.
- Run rate: MODE=01, DIV_SEL=3 -> first CLK_EN on cycle 8 after RUN entry, then exactly 1 high cycle every 8, across 10 periods. DIV_SEL=0 -> CLK_EN continuously high. DIV_SEL=31 with CNT_WIDTH=24 -> period 2^23.
- Rate change: DIV_SEL 6->2 while counter=40 -> CLK_EN on the next cycle, then every 4 cycles.
- Halt request: RUN, DIV_SEL=2, HALT_REQ pulsed 1 cycle -> STATE=00 next cycle, HALTED=1, no further CLK_EN. MODE held 01 -> stays halted. MODE 00 for 1 cycle then 01 -> RUN resumes, first pulse 4 cycles later.
- Single step (DEBOUNCE_CYCLES=4): MODE=10. STEP_BTN bounces 1/0 every 2 cycles for 20 cycles, then holds 1 for 10 -> exactly one CLK_EN. Release and press again -> second CLK_EN. Press while MODE=00 -> none.
- Step/mode collision: step_req in the same cycle MODE changes 10->01 -> one CLK_EN via STEP_FIRE, then RUN entered after the STEP_WAIT re-evaluation.
